mem_port_arbiter: RTL

Shares one single-port, line-granular physical memory between a word-wide instruction-fetch requester (I) and a word-wide data requester (D) in the single-cycle test system. Handles word extraction on reads and byte-masked read-modify-write on data stores. Grants are round-robin and non-preemptive, with one outstanding transaction at a time.

---
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one line-wide memory port between
// an instruction fetch requester and a data requester, with store merge (RMW).
module mem_port_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [31:0]           i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [3:0]            d_byte_enable,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  protocol_error
);

  localparam int WORDS = LINE_WIDTH / 32;
  localparam int OFF_W = $clog2(WORDS);
  localparam int LSB   = OFF_W + 2;
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    I_RD     = 3'd1,
    D_RD     = 3'd2,
    D_RMW_RD = 3'd3,
    D_RMW_WR = 3'd4,
    RESP     = 3'd5
  } state_t;

  typedef logic [WORDS-1:0][31:0]     line_words_t;
  typedef logic [WORDS-1:0][3:0][7:0] line_bytes_t;

  function automatic logic [31:0] get_word(input logic [LINE_WIDTH-1:0] line,
                                           input logic [OFF_W-1:0] off);
    line_words_t w;
    w = line;
    return w[off];
  endfunction

  function automatic logic [LINE_WIDTH-1:0] merge_line(input logic [LINE_WIDTH-1:0] line,
                                                       input logic [OFF_W-1:0] off,
                                                       input logic [3:0] be,
                                                       input logic [31:0] wd);
    line_bytes_t     r;
    logic [3:0][7:0] wb;
    r  = line;
    wb = wd;
    if (be[0]) r[off][2'd0] = wb[2'd0];
    if (be[1]) r[off][2'd1] = wb[2'd1];
    if (be[2]) r[off][2'd2] = wb[2'd2];
    if (be[3]) r[off][2'd3] = wb[2'd3];
    return r;
  endfunction

  state_t                state_q;
  logic                  last_grant_q;
  logic                  id_q;
  logic [OFF_W-1:0]      off_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic                  pmem_read_q;
  logic                  pmem_write_q;
  logic [ADDR_WIDTH-1:0] pmem_address_q;
  logic [LINE_WIDTH-1:0] pmem_wdata_q;
  logic                  i_resp_q;
  logic                  d_resp_q;
  logic [31:0]           i_rdata_q;
  logic [31:0]           d_rdata_q;
  logic                  perr_q;

  logic                  d_pend_s;
  logic                  grant_d_s;
  logic                  hold_ok_s;
  logic                  perr_d;
  logic [ADDR_WIDTH-1:0] req_addr_s;
  logic [LINE_WIDTH-1:0] merge_s;
  logic                  addr_unused_s;

  // Grant selection and requester-protocol monitoring
  always_comb begin
    d_pend_s   = d_read | d_write;
    grant_d_s  = d_pend_s & (~i_read | ~last_grant_q);
    req_addr_s = grant_d_s ? d_address : i_address;
    if (state_q == IDLE) begin
      hold_ok_s = 1'b1;
    end else if (id_q == REQ_D) begin
      hold_ok_s = d_pend_s;
    end else begin
      hold_ok_s = i_read;
    end
    perr_d  = perr_q | (d_read & d_write) | ~hold_ok_s;
    merge_s = merge_line(pmem_rdata, off_q, be_q, wdata_q);
  end

  assign addr_unused_s = ^req_addr_s[1:0];

  // Transaction FSM with registered memory-side and requester-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= REQ_D;
      id_q           <= REQ_I;
      off_q          <= '0;
      be_q           <= 4'd0;
      wdata_q        <= 32'd0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
      i_rdata_q      <= 32'd0;
      d_rdata_q      <= 32'd0;
      perr_q         <= 1'b0;
    end else begin
      perr_q    <= perr_d;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      case (state_q)
        IDLE: begin
          if (i_read || d_pend_s) begin
            last_grant_q <= grant_d_s;
            id_q         <= grant_d_s;
            off_q        <= req_addr_s[LSB-1:2];
            be_q         <= d_byte_enable;
            wdata_q      <= d_wdata;
            // A store with an empty mask touches nothing and completes at once
            if (grant_d_s && !d_read && (d_byte_enable == 4'd0)) begin
              d_resp_q <= 1'b1;
              state_q  <= RESP;
            end else begin
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {req_addr_s[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
              if (!grant_d_s)  state_q <= I_RD;
              else if (d_read) state_q <= D_RD;
              else             state_q <= D_RMW_RD;
            end
          end
        end
        I_RD, D_RD: begin
          if (pmem_resp) begin
            pmem_read_q    <= 1'b0;
            pmem_address_q <= '0;
            state_q        <= RESP;
            if (id_q == REQ_D) begin
              d_resp_q  <= 1'b1;
              d_rdata_q <= get_word(pmem_rdata, off_q);
            end else begin
              i_resp_q  <= 1'b1;
              i_rdata_q <= get_word(pmem_rdata, off_q);
            end
          end
        end
        D_RMW_RD: begin
          if (pmem_resp) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b1;
            pmem_wdata_q <= merge_s;
            state_q      <= D_RMW_WR;
          end
        end
        D_RMW_WR: begin
          if (pmem_resp) begin
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            d_resp_q       <= 1'b1;
            state_q        <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pmem_read      = pmem_read_q;
  assign pmem_write     = pmem_write_q;
  assign pmem_address   = pmem_address_q;
  assign pmem_wdata     = pmem_wdata_q;
  assign i_resp         = i_resp_q;
  assign d_resp         = d_resp_q;
  assign i_rdata        = i_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign protocol_error = perr_q;

endmodule
